rdm_harq_combine: RTL and testbench

//  Downstream stage of the RDM fetch FSM: consumes its 96-bit RDM chunks (16 x 6-bit signed LLRs) and combines them into the HARQ soft buffer.

---
 rtl/rdm_harq_combine_if.sv | 38 +++
 rtl/rdm_harq_combine.sv | 178 +++++++++++++++++
 tb/tb_rdm_harq_combine.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rdm_harq_combine_if.sv
// Bundle between the RDM fetch stage, the HARQ soft-buffer RAM and the combine block.
// A beat transfers on a cycle where i_RDM_Data_Valid is high while o_RDM_Data_Request is high; no other backpressure.
interface rdm_harq_combine_if #(
  parameter int DW = 96
);
  logic          i_Combine_process_request;
  logic [15:0]   i_Current_Combine_Ncb_Size;
  logic          i_New_Data_Indicator;
  logic          o_RDM_Data_Request;
  logic          i_RDM_Data_Valid;
  logic [DW-1:0] i_RDM_Data_Content;
  logic          i_RDM_Data_Comp;
  logic          o_Harq_Rd_En;
  logic [11:0]   o_Harq_Rd_Addr;
  logic [DW-1:0] i_Harq_Rd_Data;
  logic          o_Harq_Wr_En;
  logic [11:0]   o_Harq_Wr_Addr;
  logic [DW-1:0] o_Harq_Wr_Data;
  logic          o_Combine_Busy;
  logic          o_Combine_Done;
  logic [1:0]    dbg_state;

  modport master (
    output i_Combine_process_request, i_Current_Combine_Ncb_Size, i_New_Data_Indicator,
    output i_RDM_Data_Valid, i_RDM_Data_Content, i_RDM_Data_Comp, i_Harq_Rd_Data,
    input  o_RDM_Data_Request, o_Harq_Rd_En, o_Harq_Rd_Addr,
    input  o_Harq_Wr_En, o_Harq_Wr_Addr, o_Harq_Wr_Data,
    input  o_Combine_Busy, o_Combine_Done, dbg_state
  );

  modport slave (
    input  i_Combine_process_request, i_Current_Combine_Ncb_Size, i_New_Data_Indicator,
    input  i_RDM_Data_Valid, i_RDM_Data_Content, i_RDM_Data_Comp, i_Harq_Rd_Data,
    output o_RDM_Data_Request, o_Harq_Rd_En, o_Harq_Rd_Addr,
    output o_Harq_Wr_En, o_Harq_Wr_Addr, o_Harq_Wr_Data,
    output o_Combine_Busy, o_Combine_Done, dbg_state
  );
endinterface

// File: rtl/rdm_harq_combine.sv
// Saturating read-modify-write combining of RDM beats into the circular HARQ soft buffer,
// with forwarding of not-yet-visible writes so short buffers combine correctly.
module rdm_harq_combine #(
  parameter int LLR_W  = 6,
  parameter int LANES  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              i_core_clk,
  input  logic              i_rx_rst,
  rdm_harq_combine_if.slave bus
);
  localparam int DW  = LLR_W * LANES;
  localparam int AW  = 12;
  localparam int LNW = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [AW-1:0]     ptr;
  logic [AW-1:0]     last_word;
  logic [LANES-1:0]  last_mask;
  logic              ind;
  logic              req;
  logic              busy;
  logic              done;

  // Stage i holds the beat accepted i cycles ago; its RAM data arrives at stage RD_LAT.
  logic              s_v    [1:RD_LAT];
  logic [AW-1:0]     s_addr [1:RD_LAT];
  logic [DW-1:0]     s_data [1:RD_LAT];
  logic              s_last [1:RD_LAT];

  // Entry 0 is the write being issued now; entry j was issued j cycles ago.
  logic              h_v    [0:RD_LAT];
  logic [AW-1:0]     h_addr [0:RD_LAT];
  logic [DW-1:0]     h_data [0:RD_LAT];

  logic              beat;
  logic              at_last;
  logic              pipe_empty;
  logic [DW-1:0]     old_word;
  logic [DW-1:0]     comb_word;

  function automatic logic [LLR_W-1:0] sat_add(input logic [LLR_W-1:0] a, input logic [LLR_W-1:0] b);
    logic [LLR_W:0] s;
    s = {a[LLR_W-1], a} + {b[LLR_W-1], b};
    if (s[LLR_W] != s[LLR_W-1])
      sat_add = s[LLR_W] ? {1'b1, {(LLR_W-1){1'b0}}} : {1'b0, {(LLR_W-1){1'b1}}};
    else
      sat_add = s[LLR_W-1:0];
  endfunction

  function automatic logic [LANES-1:0] lane_mask(input logic [LNW-1:0] n);
    lane_mask = '0;
    for (int k = 0; k < LANES; k++)
      lane_mask[k] = (LNW'(k) <= n);
  endfunction

  assign beat    = (state == RUN) && bus.i_RDM_Data_Valid;
  assign at_last = (ptr == last_word);

  always_comb begin
    pipe_empty = !h_v[0];
    for (int i = 1; i <= RD_LAT; i++)
      if (s_v[i]) pipe_empty = 1'b0;
  end

  // Writes issued since the read was launched are not in the RAM data; newest match wins.
  always_comb begin
    old_word = bus.i_Harq_Rd_Data;
    for (int j = RD_LAT; j >= 0; j--)
      if (h_v[j] && (h_addr[j] == s_addr[RD_LAT])) old_word = h_data[j];
    if (ind) old_word = '0;
  end

  always_comb begin
    comb_word = '0;
    for (int k = 0; k < LANES; k++) begin
      if (s_last[RD_LAT] && !last_mask[k])
        comb_word[k*LLR_W +: LLR_W] = old_word[k*LLR_W +: LLR_W];
      else
        comb_word[k*LLR_W +: LLR_W] = sat_add(s_data[RD_LAT][k*LLR_W +: LLR_W],
                                              old_word[k*LLR_W +: LLR_W]);
    end
  end

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      state     <= IDLE;
      ptr       <= '0;
      last_word <= '0;
      last_mask <= '0;
      ind       <= 1'b0;
      req       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 1; i <= RD_LAT; i++) begin
        s_v[i]    <= 1'b0;
        s_addr[i] <= '0;
        s_data[i] <= '0;
        s_last[i] <= 1'b0;
      end
      for (int j = 0; j <= RD_LAT; j++) begin
        h_v[j]    <= 1'b0;
        h_addr[j] <= '0;
        h_data[j] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_Combine_process_request) begin
            state     <= RUN;
            ptr       <= '0;
            last_word <= bus.i_Current_Combine_Ncb_Size[15:LNW];
            last_mask <= lane_mask(bus.i_Current_Combine_Ncb_Size[LNW-1:0]);
            ind       <= bus.i_New_Data_Indicator;
            req       <= 1'b1;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (beat) ptr <= at_last ? '0 : ptr + AW'(1);
          if (bus.i_RDM_Data_Comp) begin
            state <= DRAIN;
            req   <= 1'b0;
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      s_v[1]    <= beat;
      s_addr[1] <= ptr;
      s_data[1] <= bus.i_RDM_Data_Content;
      s_last[1] <= at_last;
      for (int i = 2; i <= RD_LAT; i++) begin
        s_v[i]    <= s_v[i-1];
        s_addr[i] <= s_addr[i-1];
        s_data[i] <= s_data[i-1];
        s_last[i] <= s_last[i-1];
      end

      h_v[0]    <= s_v[RD_LAT];
      h_addr[0] <= s_addr[RD_LAT];
      h_data[0] <= comb_word;
      for (int j = 1; j <= RD_LAT; j++) begin
        h_v[j]    <= h_v[j-1];
        h_addr[j] <= h_addr[j-1];
        h_data[j] <= h_data[j-1];
      end
    end
  end

  assign bus.o_RDM_Data_Request = req;
  assign bus.o_Harq_Rd_En       = beat && !ind;
  assign bus.o_Harq_Rd_Addr     = ptr;
  assign bus.o_Harq_Wr_En       = h_v[0];
  assign bus.o_Harq_Wr_Addr     = h_addr[0];
  assign bus.o_Harq_Wr_Data     = h_data[0];
  assign bus.o_Combine_Busy     = busy;
  assign bus.o_Combine_Done     = done;
  assign bus.dbg_state          = state;
endmodule

// File: tb/tb_rdm_harq_combine.sv
// Drives identical jobs into an RD_LAT=2 and an RD_LAT=1 instance, each with its own RAM model,
// and checks write addresses, final RAM contents, read counts and control timing.
module tb_rdm_harq_combine;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rdm_harq_combine_if ifa();
  rdm_harq_combine_if ifb();

  logic        start;
  logic [15:0] ncb;
  logic        ind;
  logic        valid;
  logic [95:0] content;
  logic        comp;

  assign ifa.i_Combine_process_request  = start;
  assign ifa.i_Current_Combine_Ncb_Size = ncb;
  assign ifa.i_New_Data_Indicator       = ind;
  assign ifa.i_RDM_Data_Valid           = valid;
  assign ifa.i_RDM_Data_Content         = content;
  assign ifa.i_RDM_Data_Comp            = comp;
  assign ifb.i_Combine_process_request  = start;
  assign ifb.i_Current_Combine_Ncb_Size = ncb;
  assign ifb.i_New_Data_Indicator       = ind;
  assign ifb.i_RDM_Data_Valid           = valid;
  assign ifb.i_RDM_Data_Content         = content;
  assign ifb.i_RDM_Data_Comp            = comp;

  rdm_harq_combine #(.LLR_W(6), .LANES(16), .RD_LAT(2)) dut_a (
    .i_core_clk (clk),
    .i_rx_rst   (rst),
    .bus        (ifa)
  );

  rdm_harq_combine #(.LLR_W(6), .LANES(16), .RD_LAT(1)) dut_b (
    .i_core_clk (clk),
    .i_rx_rst   (rst),
    .bus        (ifb)
  );

  // RAM models: read returns pre-write contents on a same-edge collision
  logic [95:0] ram_a [0:4095];
  logic [95:0] ram_b [0:4095];
  logic [95:0] rda_q1, rda_q2, rdb_q1;
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [95:0] pre_data;

  always @(posedge clk) begin
    if (ifa.o_Harq_Rd_En) rda_q1 <= ram_a[ifa.o_Harq_Rd_Addr];
    rda_q2 <= rda_q1;
    if (ifb.o_Harq_Rd_En) rdb_q1 <= ram_b[ifb.o_Harq_Rd_Addr];
    if (pre_en) begin
      ram_a[pre_addr] <= pre_data;
      ram_b[pre_addr] <= pre_data;
    end else begin
      if (ifa.o_Harq_Wr_En) ram_a[ifa.o_Harq_Wr_Addr] <= ifa.o_Harq_Wr_Data;
      if (ifb.o_Harq_Wr_En) ram_b[ifb.o_Harq_Wr_Addr] <= ifb.o_Harq_Wr_Data;
    end
  end
  assign ifa.i_Harq_Rd_Data = rda_q2;
  assign ifb.i_Harq_Rd_Data = rdb_q1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected write addresses, in order, per instance
  logic [11:0] exp_qa[$];
  logic [11:0] exp_qb[$];
  int rd_cnt_a = 0;
  int rd_cnt_b = 0;

  always @(negedge clk) begin
    if (ifa.o_Harq_Rd_En) rd_cnt_a++;
    if (ifb.o_Harq_Rd_En) rd_cnt_b++;
    if (ifa.o_Harq_Wr_En) begin
      if (exp_qa.size() == 0) check("wr_extra_a", 96'(ifa.o_Harq_Wr_En), 96'd0);
      else check("wr_addr_a", 96'(ifa.o_Harq_Wr_Addr), 96'(exp_qa.pop_front()));
    end
    if (ifb.o_Harq_Wr_En) begin
      if (exp_qb.size() == 0) check("wr_extra_b", 96'(ifb.o_Harq_Wr_En), 96'd0);
      else check("wr_addr_b", 96'(ifb.o_Harq_Wr_Addr), 96'(exp_qb.pop_front()));
    end
  end

  function automatic logic [95:0] rep(input logic [5:0] v);
    logic [95:0] w;
    for (int k = 0; k < 16; k++) w[k*6 +: 6] = v;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [11:0] a, input logic [95:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic expect_addr(input logic [11:0] a);
    exp_qa.push_back(a);
    exp_qb.push_back(a);
  endtask

  task automatic start_job(input logic [15:0] n, input logic i);
    start = 1'b1; ncb = n; ind = i;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [95:0] d, input logic c);
    valid = 1'b1; content = d; comp = c;
    tick();
    valid = 1'b0; comp = 1'b0;
  endtask

  // Called right after the Comp beat; n counts negedges from the following cycle
  task automatic wait_done(input int exp_a, input int exp_b);
    int lat_a, lat_b;
    lat_a = -1; lat_b = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n == 0) begin
        check("req_drop_a", 96'(ifa.o_RDM_Data_Request), 96'd0);
        check("req_drop_b", 96'(ifb.o_RDM_Data_Request), 96'd0);
      end
      if (lat_a < 0 && ifa.o_Combine_Done) begin
        lat_a = n;
        check("busy_in_done_a", 96'(ifa.o_Combine_Busy), 96'd1);
      end
      if (lat_b < 0 && ifb.o_Combine_Done) begin
        lat_b = n;
        check("busy_in_done_b", 96'(ifb.o_Combine_Busy), 96'd1);
      end
      if (lat_a >= 0 && lat_b >= 0) break;
    end
    check("done_lat_a", 96'(lat_a), 96'(exp_a));
    check("done_lat_b", 96'(lat_b), 96'(exp_b));
  endtask

  task automatic check_word(input string tag, input logic [11:0] a, input logic [95:0] exp);
    check({tag, "_a"}, ram_a[a], exp);
    check({tag, "_b"}, ram_b[a], exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl_a"}, 96'({ifa.o_Harq_Rd_En, ifa.o_Harq_Wr_En, ifa.o_RDM_Data_Request,
                               ifa.o_Combine_Busy, ifa.o_Combine_Done, ifa.dbg_state}), 96'd0);
    check({tag, "_ctl_b"}, 96'({ifb.o_Harq_Rd_En, ifb.o_Harq_Wr_En, ifb.o_RDM_Data_Request,
                               ifb.o_Combine_Busy, ifb.o_Combine_Done, ifb.dbg_state}), 96'd0);
    check({tag, "_addr_a"}, 96'({ifa.o_Harq_Rd_Addr, ifa.o_Harq_Wr_Addr}), 96'd0);
    check({tag, "_addr_b"}, 96'({ifb.o_Harq_Rd_Addr, ifb.o_Harq_Wr_Addr}), 96'd0);
    check({tag, "_wdata_a"}, ifa.o_Harq_Wr_Data, 96'd0);
    check({tag, "_wdata_b"}, ifb.o_Harq_Wr_Data, 96'd0);
  endtask

  initial begin
    int ra, rb;
    logic [95:0] w;
    rst = 1'b1; start = 1'b0; ncb = '0; ind = 1'b0; valid = 1'b0; content = '0; comp = 1'b0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // T1: first transmission overwrites stale data without reading
    for (int i = 0; i < 3; i++) preset(12'(i), rep(6'd7));
    for (int i = 0; i < 3; i++) expect_addr(12'(i));
    ra = rd_cnt_a; rb = rd_cnt_b;
    start_job(16'h002F, 1'b1);
    @(negedge clk);
    check("run_req_a", 96'({ifa.o_RDM_Data_Request, ifa.o_Combine_Busy, ifa.dbg_state}), 96'b1101);
    check("run_req_b", 96'({ifb.o_RDM_Data_Request, ifb.o_Combine_Busy, ifb.dbg_state}), 96'b1101);
    send_beat(rep(6'd5), 1'b0);
    send_beat(rep(6'd5), 1'b0);
    send_beat(rep(6'd5), 1'b1);
    wait_done(4, 3);
    for (int i = 0; i < 3; i++) check_word("t1_word", 12'(i), rep(6'd5));
    check("t1_rd_a", 96'(rd_cnt_a - ra), 96'd0);
    check("t1_rd_b", 96'(rd_cnt_b - rb), 96'd0);
    tick();
    @(negedge clk);
    check("t1_after_a", 96'({ifa.o_Combine_Busy, ifa.o_Combine_Done, ifa.dbg_state}), 96'd0);
    check("t1_after_b", 96'({ifb.o_Combine_Busy, ifb.o_Combine_Done, ifb.dbg_state}), 96'd0);

    // T2: saturation both directions, then in-range sums
    preset(12'd0, rep(6'd30));
    preset(12'd1, rep(6'h22));
    expect_addr(12'd0); expect_addr(12'd1);
    ra = rd_cnt_a;
    start_job(16'h001F, 1'b0);
    send_beat(rep(6'd3), 1'b0);
    send_beat(rep(6'h3B), 1'b1);
    wait_done(4, 3);
    check_word("t2_sat_pos", 12'd0, rep(6'h1F));
    check_word("t2_sat_neg", 12'd1, rep(6'h20));
    check("t2_rd_a", 96'(rd_cnt_a - ra), 96'd2);
    preset(12'd0, rep(6'd30));
    preset(12'd1, rep(6'h22));
    expect_addr(12'd0); expect_addr(12'd1);
    start_job(16'h001F, 1'b0);
    send_beat(rep(6'd1), 1'b0);
    send_beat(rep(6'h3F), 1'b1);
    wait_done(4, 3);
    check_word("t2_pos31", 12'd0, rep(6'h1F));
    check_word("t2_neg31", 12'd1, rep(6'h21));

    // T3: partial last word and repetition wrap; upper lanes of word 1 must keep 9
    for (int k = 0; k < 16; k++) w[k*6 +: 6] = (k < 4) ? 6'd0 : 6'd9;
    preset(12'd0, rep(6'd0));
    preset(12'd1, w);
    expect_addr(12'd0); expect_addr(12'd1); expect_addr(12'd0); expect_addr(12'd1); expect_addr(12'd0);
    ra = rd_cnt_a; rb = rd_cnt_b;
    start_job(16'h0013, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(rep(6'd1), 1'b0);
    send_beat(rep(6'd1), 1'b1);
    wait_done(4, 3);
    check_word("t3_word0", 12'd0, rep(6'd3));
    for (int k = 0; k < 16; k++) w[k*6 +: 6] = (k < 4) ? 6'd2 : 6'd9;
    check_word("t3_word1", 12'd1, w);
    check("t3_rd_a", 96'(rd_cnt_a - ra), 96'd5);
    check("t3_rd_b", 96'(rd_cnt_b - rb), 96'd5);

    // T4: single-word buffer, back-to-back beats need forwarding
    preset(12'd0, rep(6'd0));
    for (int i = 0; i < 4; i++) expect_addr(12'd0);
    start_job(16'h000F, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(rep(6'd2), 1'b0);
    send_beat(rep(6'd2), 1'b1);
    wait_done(4, 3);
    check_word("t4_fwd", 12'd0, rep(6'd8));

    // T5: beats in IDLE are ignored, gaps, a stray start mid-job, Comp on last beat
    ra = rd_cnt_a; rb = rd_cnt_b;
    send_beat(rep(6'd5), 1'b0);
    tick();
    check("t5_idle_rd_a", 96'(rd_cnt_a - ra), 96'd0);
    check("t5_idle_rd_b", 96'(rd_cnt_b - rb), 96'd0);
    for (int i = 0; i < 3; i++) preset(12'(i), rep(6'd0));
    expect_addr(12'd0); expect_addr(12'd1); expect_addr(12'd2); expect_addr(12'd0);
    start_job(16'h002F, 1'b0);
    send_beat(rep(6'd1), 1'b0);
    repeat ($urandom_range(0, 3)) tick();
    send_beat(rep(6'd2), 1'b0);
    start = 1'b1; ncb = 16'h0000; ind = 1'b1;
    tick();
    start = 1'b0;
    repeat ($urandom_range(0, 3)) tick();
    send_beat(rep(6'd3), 1'b0);
    repeat ($urandom_range(0, 3)) tick();
    send_beat(rep(6'd4), 1'b1);
    wait_done(4, 3);
    check_word("t5_word0", 12'd0, rep(6'd5));
    check_word("t5_word1", 12'd1, rep(6'd2));
    check_word("t5_word2", 12'd2, rep(6'd3));
    send_beat(rep(6'd6), 1'b0);
    repeat (5) tick();
    check("t5_noextra_a", 96'(exp_qa.size()), 96'd0);
    check("t5_noextra_b", 96'(exp_qb.size()), 96'd0);

    // T6: reset with reads in flight abandons the job
    for (int i = 0; i < 3; i++) preset(12'(i), rep(6'd6));
    start_job(16'h002F, 1'b0);
    send_beat(rep(6'd1), 1'b0);
    valid = 1'b1; content = rep(6'd1); rst = 1'b1;
    tick();
    valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("t6_reset");
    repeat (6) tick();
    for (int i = 0; i < 3; i++) check_word("t6_untouched", 12'(i), rep(6'd6));
    expect_addr(12'd0);
    start_job(16'h000F, 1'b0);
    send_beat(rep(6'd1), 1'b1);
    wait_done(4, 3);
    check_word("t6_fresh", 12'd0, rep(6'd7));

    check("final_queue_a", 96'(exp_qa.size()), 96'd0);
    check("final_queue_b", 96'(exp_qb.size()), 96'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
